// File: rtl/vu_meter_ctrl.sv
// rtl/vu_meter_ctrl.sv - windowed peak level meter with bar decay, peak-hold dot and active-low LED bar
module vu_meter_ctrl #(
  parameter int REFRESH_DIV   = 3000000,
  parameter int DECAY_WINDOWS = 2,
  parameter int HOLD_WINDOWS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        frame_tick,
  output logic [3:0]  level,
  output logic [3:0]  peak_level,
  output logic [7:0]  led
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DECAY_WINDOWS > 1) ? $clog2(DECAY_WINDOWS) : 1;
  localparam int HW = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_WINDOWS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_WINDOWS - 1);

  logic [CW-1:0] cnt;
  logic [14:0]   win_max;
  logic [DW-1:0] decay_cnt;
  logic [HW-1:0] hold_cnt;

  logic          term;
  logic [14:0]   mag;
  logic [14:0]   close_val;
  logic [3:0]    n_lvl;
  logic [3:0]    lv_next;
  logic [3:0]    pk_next;
  logic [DW-1:0] dc_next;
  logic [HW-1:0] hc_next;
  logic [7:0]    led_next;

  // Bar index of a magnitude: two bits of magnitude per LED, 0 only for silence.
  function automatic logic [3:0] bar_of(input logic [14:0] m);
    bar_of = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (m[i]) bar_of = 4'(i / 2 + 1);
    end
  endfunction

  assign term = (cnt == CNT_LAST);

  // Magnitude of the incoming sample; the most negative code clips to full scale.
  always_comb begin
    mag = sample_data[14:0];
    if (sample_data == 16'h8000) begin
      mag = 15'h7FFF;
    end else if (sample_data[15]) begin
      mag = ~sample_data[14:0] + 15'd1;
    end
  end

  // Window-close update: a sample arriving on the terminal cycle still belongs to the closing window.
  always_comb begin
    close_val = (sample_valid && (mag > win_max)) ? mag : win_max;
    n_lvl     = bar_of(close_val);

    lv_next = level;
    dc_next = decay_cnt + DW'(1);
    if (n_lvl >= level) begin
      lv_next = n_lvl;
      dc_next = '0;
    end else if (decay_cnt == DECAY_LAST) begin
      lv_next = level - 4'd1;
      dc_next = '0;
    end

    pk_next = peak_level;
    hc_next = hold_cnt + HW'(1);
    if (n_lvl >= peak_level) begin
      pk_next = n_lvl;
      hc_next = '0;
    end else if (hold_cnt == HOLD_LAST) begin
      pk_next = lv_next;
      hc_next = '0;
    end

    led_next = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < lv_next) || ((pk_next != 4'd0) && (4'(i) == pk_next - 4'd1))) begin
        led_next[i] = 1'b0;
      end
    end
  end

  // Window counter, peak accumulator and the registered display state updated together at each close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      win_max    <= '0;
      decay_cnt  <= '0;
      hold_cnt   <= '0;
      level      <= 4'd0;
      peak_level <= 4'd0;
      frame_tick <= 1'b0;
      led        <= 8'hFF;
    end else begin
      frame_tick <= term;
      if (term) begin
        cnt        <= '0;
        win_max    <= '0;
        level      <= lv_next;
        decay_cnt  <= dc_next;
        peak_level <= pk_next;
        hold_cnt   <= hc_next;
        led        <= led_next;
      end else begin
        cnt <= cnt + CW'(1);
        if (sample_valid && (mag > win_max)) begin
          win_max <= mag;
        end
      end
    end
  end

endmodule

// File: tb/tb_vu_meter_ctrl.sv
// tb/tb_vu_meter_ctrl.sv - directed scoreboard bench for vu_meter_ctrl
module tb_vu_meter_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        frame_tick;
  logic [3:0]  level;
  logic [3:0]  peak_level;
  logic [7:0]  led;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  int sl_l[16]   = '{8, 7, 7, 6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0};
  int sl_p[16]   = '{8, 8, 8, 6, 6, 6, 6, 4, 4, 4, 4, 2, 2, 2, 2, 0};
  int sl_led[16] = '{'h00, 'h00, 'h00, 'hC0, 'hC0, 'hC0, 'hC0, 'hF0,
                     'hF0, 'hF0, 'hF0, 'hFC, 'hFC, 'hFC, 'hFC, 'hFF};

  vu_meter_ctrl #(
    .REFRESH_DIV  (16),
    .DECAY_WINDOWS(2),
    .HOLD_WINDOWS (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .frame_tick  (frame_tick),
    .level       (level),
    .peak_level  (peak_level),
    .led         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int el, input int ep, input int eled);
    exp_q.push_back({4'(el), 4'(ep), 8'(eled)});
  endtask

  // Called on the negedge right after a window close edge.
  task automatic close_check(input string tag);
    logic [15:0] e;
    chk({tag, ".tick"}, {31'd0, frame_tick}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".level"}, {28'd0, level}, {28'd0, e[15:12]});
      chk({tag, ".peak"}, {28'd0, peak_level}, {28'd0, e[11:8]});
      chk({tag, ".led"}, {24'd0, led}, {24'd0, e[7:0]});
    end
  endtask

  // Starts on the negedge of cnt==0; position k drives the sample for cnt==k.
  task automatic run_window(input string tag, input int p0, input logic [15:0] d0,
                            input int p1, input logic [15:0] d1,
                            input bit fill, input logic [15:0] fd,
                            input int el, input int ep, input int eled);
    push_exp(el, ep, eled);
    for (int k = 0; k < 16; k++) begin
      sample_valid = fill || (k == p0) || (k == p1);
      sample_data  = (k == p0) ? d0 : (k == p1) ? d1 : fill ? fd : 16'h0000;
      if (k == 1) chk({tag, ".pulse1"}, {31'd0, frame_tick}, 32'd0);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    sample_data  = 16'h0000;
    close_check(tag);
  endtask

  task automatic wait_first_tick(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_tick !== 1'b1 && cyc < 40);
    chk({tag, ".latency"}, 32'(cyc), 32'd16);
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("por.led", {24'd0, led}, 32'hFF);
    chk("por.tick", {31'd0, frame_tick}, 32'd0);
    rst_n = 1'b1;
    push_exp(0, 0, 'hFF);
    wait_first_tick("por");
    close_check("por");

    run_window("single", 3, 16'h0100, -1, 16'h0, 0, 16'h0, 5, 5, 'hE0);

    // Partial window with a loud sample, then asynchronous reset mid-window.
    for (int k = 0; k < 5; k++) begin
      sample_valid = (k == 2);
      sample_data  = (k == 2) ? 16'h7FFF : 16'h0000;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    sample_data  = 16'h0000;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.led", {24'd0, led}, 32'hFF);
    chk("arst.level", {28'd0, level}, 32'd0);
    chk("arst.peak", {28'd0, peak_level}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(0, 0, 'hFF);
    wait_first_tick("arst");
    close_check("arst");

    run_window("sat", 2, 16'h8000, 9, 16'h0003, 0, 16'h0, 8, 8, 'h00);
    for (int w = 0; w < 16; w++) begin
      run_window($sformatf("silence%0d", w + 1), -1, 16'h0, -1, 16'h0, 0, 16'h0,
                 sl_l[w], sl_p[w], sl_led[w]);
    end
    run_window("minus1", 6, 16'hFFFF, -1, 16'h0, 0, 16'h0, 1, 1, 'hFE);

    run_window("term", 15, 16'h4000, -1, 16'h0, 0, 16'h0, 8, 8, 'h00);
    run_window("post_term1", -1, 16'h0, -1, 16'h0, 0, 16'h0, 8, 8, 'h00);
    run_window("post_term2", -1, 16'h0, -1, 16'h0, 0, 16'h0, 7, 8, 'h00);
    run_window("post_term3", -1, 16'h0, -1, 16'h0, 0, 16'h0, 7, 8, 'h00);
    run_window("post_term4", -1, 16'h0, -1, 16'h0, 0, 16'h0, 6, 6, 'hC0);

    run_window("reattack_low", 4, 16'h0010, -1, 16'h0, 0, 16'h0, 6, 6, 'hC0);
    run_window("reattack_full", 11, 16'h7FFF, -1, 16'h0, 0, 16'h0, 8, 8, 'h00);
    run_window("ra_sil1", -1, 16'h0, -1, 16'h0, 0, 16'h0, 8, 8, 'h00);
    run_window("ra_sil2", -1, 16'h0, -1, 16'h0, 0, 16'h0, 7, 8, 'h00);
    run_window("ra_sil3", -1, 16'h0, -1, 16'h0, 0, 16'h0, 7, 8, 'h00);
    run_window("ra_sil4", -1, 16'h0, -1, 16'h0, 0, 16'h0, 6, 6, 'hC0);

    run_window("b2b", 14, 16'hC000, -1, 16'h0, 1, 16'h0002, 8, 8, 'h00);
    run_window("b2b_after", -1, 16'h0, -1, 16'h0, 0, 16'h0, 8, 8, 'h00);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
